// File: rtl/font_row_serializer_if.sv
// -----------------------------------------------------------------------------
// font_row_serializer_if
//   Groups the row-request and pixel-stream handshakes of font_row_serializer.
//
//   Parameters
//     GIDX_W  width of glyph_idx (match the serializer's max(1,clog2(NUM_GLYPHS)))
//     RIDX_W  width of row_idx   (match the serializer's clog2(GLYPH_ROWS))
//
//   Signals
//     req_valid  requester -> serializer  row request valid
//     req_ready  serializer -> requester  serializer idle, request taken on valid&ready
//     glyph_idx  requester -> serializer  glyph number
//     row_idx    requester -> serializer  row within glyph, 0 = top
//     pix_valid  serializer -> consumer   pixel beat valid
//     pix_ready  consumer -> serializer   consumer accepts beat
//     pix_bit    serializer -> consumer   pixel value, 1 = foreground
//     pix_last   serializer -> consumer   final beat of the row
//
//   Modports
//     master  requester / pixel consumer side
//     slave   serializer side
// -----------------------------------------------------------------------------
interface font_row_serializer_if #(
    parameter int unsigned GIDX_W = 2,
    parameter int unsigned RIDX_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [GIDX_W-1:0] glyph_idx;
    logic [RIDX_W-1:0] row_idx;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_bit;
    logic              pix_last;

    modport master (
        output req_valid,
        output glyph_idx,
        output row_idx,
        output pix_ready,
        input  req_ready,
        input  pix_valid,
        input  pix_bit,
        input  pix_last
    );

    modport slave (
        input  req_valid,
        input  glyph_idx,
        input  row_idx,
        input  pix_ready,
        output req_ready,
        output pix_valid,
        output pix_bit,
        output pix_last
    );
endinterface

// File: rtl/font_row_serializer.sv
// -----------------------------------------------------------------------------
// font_row_serializer
//   Glyph ROM plus row serializer for the VGA text path. A (glyph, row) request
//   is accepted while idle, the glyph row is read from the internal ROM into a
//   shift register, and the row is shifted out MSB first, one pixel per
//   accepted beat, each pixel repeated SCALE times. The pixel stream obeys
//   valid/ready backpressure.
//
//   Parameters
//     GLYPH_W     pixels per glyph row (ROM word width)
//     GLYPH_ROWS  rows per glyph, power of 2
//     NUM_GLYPHS  glyphs stored; ROM depth = NUM_GLYPHS*GLYPH_ROWS
//     SCALE       beats per pixel (horizontal replication), 1..8
//     INIT_FILE   kept for compatibility; the ROM always uses the built-in table
//
//   Ports
//     clk    system clock, all state on the rising edge
//     reset  asynchronous, active-high reset
//     bus    font_row_serializer_if.slave: req_valid/req_ready/glyph_idx/
//            row_idx request side, pix_valid/pix_ready/pix_bit/pix_last
//            pixel stream side
//
//   Timing
//     Request accepted in cycle N -> FETCH in N+1 -> first pixel beat in N+2.
//     At full throughput a row occupies GLYPH_W*SCALE + 2 cycles.
// -----------------------------------------------------------------------------
module font_row_serializer #(
    parameter int unsigned GLYPH_W    = 8,
    parameter int unsigned GLYPH_ROWS = 16,
    parameter int unsigned NUM_GLYPHS = 4,
    parameter int unsigned SCALE      = 1,
    parameter string       INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    font_row_serializer_if.slave  bus
);

    localparam int unsigned GIDX_W = (NUM_GLYPHS > 1) ? $clog2(NUM_GLYPHS) : 1;
    localparam int unsigned RIDX_W = $clog2(GLYPH_ROWS);
    localparam int unsigned ADDR_W = GIDX_W + RIDX_W;
    localparam int unsigned DEPTH  = NUM_GLYPHS * GLYPH_ROWS;
    localparam int unsigned BIT_W  = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int unsigned REP_W  = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(GLYPH_W - 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(SCALE - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT
    } state_t;

    // -------------------------------------------------------------------------
    // Built-in font: reference table is 8 pixels x 16 rows x 4 glyphs.
    // -------------------------------------------------------------------------
    function automatic logic [7:0] base_row(input int unsigned g, input int unsigned r);
        logic [7:0] v;
        v = 8'h00;
        case (g)
            1: begin   // 'I'
                case (r)
                    1, 2, 12, 13:                   v = 8'hFF;
                    3, 4, 5, 6, 7, 8, 9, 10, 11:    v = 8'h38;
                    default:                        v = 8'h00;
                endcase
            end
            2: begin   // 'S'
                case (r)
                    1, 2, 7, 8, 12, 13:             v = 8'hFF;
                    3, 4, 5, 6:                     v = 8'hE0;
                    9, 10, 11:                      v = 8'h07;
                    default:                        v = 8'h00;
                endcase
            end
            3: begin   // 'A'
                case (r)
                    1:                              v = 8'h10;
                    2:                              v = 8'h38;
                    3:                              v = 8'h6C;
                    4, 5, 6, 7, 10, 11, 12, 13:     v = 8'hC6;
                    8, 9:                           v = 8'hFE;
                    default:                        v = 8'h00;
                endcase
            end
            default: v = 8'h00;   // glyph 0 blank, glyphs beyond the table blank
        endcase
        return v;
    endfunction

    // Fit the 8-pixel reference row to GLYPH_W: columns are kept left-aligned,
    // so narrower glyphs drop rightmost pixels and wider ones pad blank on the right.
    function automatic logic [GLYPH_W-1:0] builtin_word(input int unsigned g,
                                                        input int unsigned r);
        logic [7:0]         b;
        logic [GLYPH_W-1:0] w;
        w = '0;
        b = base_row(g, r);
        for (int unsigned c = 0; c < GLYPH_W; c++) begin
            if (c < 8) begin
                w[GLYPH_W-1-c] = b[7-c];
            end
        end
        return w;
    endfunction

    // -------------------------------------------------------------------------
    // ROM storage
    // -------------------------------------------------------------------------
    logic [GLYPH_W-1:0] rom [DEPTH];

    generate
        for (genvar a = 0; a < DEPTH; a++) begin : g_word
            assign rom[a] = builtin_word(a / GLYPH_ROWS, a % GLYPH_ROWS);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t             state_q,   state_d;
    logic [GIDX_W-1:0]  glyph_q,   glyph_d;
    logic [RIDX_W-1:0]  row_q,     row_d;
    logic [GLYPH_W-1:0] shreg_q,   shreg_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;

    // GLYPH_ROWS is a power of 2, so concatenation equals glyph*GLYPH_ROWS+row.
    logic [ADDR_W-1:0]  rom_addr;
    logic [GLYPH_W-1:0] rom_word;
    logic               glyph_in_range;
    logic               rep_done;
    logic               row_done;

    assign rom_addr       = {glyph_q, row_q};
    assign glyph_in_range = (32'(glyph_q) < NUM_GLYPHS);
    // Indices past the stored glyphs read as a blank row; the row is still emitted.
    assign rom_word       = glyph_in_range ? rom[rom_addr] : '0;

    assign rep_done = (rep_cnt_q == REP_LAST);
    assign row_done = (bit_cnt_q == BIT_LAST) && rep_done;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            glyph_q   <= '0;
            row_q     <= '0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            glyph_q   <= glyph_d;
            row_q     <= row_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        glyph_d       = glyph_q;
        row_d         = row_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        rep_cnt_d     = rep_cnt_q;

        bus.req_ready = (state_q == IDLE);
        bus.pix_valid = (state_q == SHIFT);
        bus.pix_bit   = (state_q == SHIFT) && shreg_q[GLYPH_W-1];
        bus.pix_last  = (state_q == SHIFT) && row_done;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    glyph_d = bus.glyph_idx;
                    row_d   = bus.row_idx;
                    state_d = FETCH;
                end
            end

            FETCH: begin
                shreg_d   = rom_word;
                bit_cnt_d = '0;
                rep_cnt_d = '0;
                state_d   = SHIFT;
            end

            SHIFT: begin
                // Without pix_ready nothing moves, so bit/last stay stable.
                if (bus.pix_ready) begin
                    if (rep_done) begin
                        rep_cnt_d = '0;
                        shreg_d   = shreg_q << 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (row_done) begin
                            state_d = IDLE;
                        end
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_font_row_serializer.sv
// -----------------------------------------------------------------------------
// tb_font_row_serializer
//   Two serializers: dut_a (SCALE=1, NUM_GLYPHS=5 so out-of-range indices are
//   expressible) and dut_b (SCALE=2, default glyph count). Each request pushes
//   its expected beats (bit,last) into a per-DUT queue; every accepted pixel
//   beat pops and compares. Inputs change on the falling edge, outputs are
//   sampled there too.
// -----------------------------------------------------------------------------
module tb_font_row_serializer;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    font_row_serializer_if #(.GIDX_W(3), .RIDX_W(4)) a_if ();
    font_row_serializer_if #(.GIDX_W(2), .RIDX_W(4)) b_if ();

    font_row_serializer #(
        .GLYPH_W    (8),
        .GLYPH_ROWS (16),
        .NUM_GLYPHS (5),
        .SCALE      (1),
        .INIT_FILE  ("")
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if.slave)
    );

    font_row_serializer #(
        .GLYPH_W    (8),
        .GLYPH_ROWS (16),
        .NUM_GLYPHS (4),
        .SCALE      (2),
        .INIT_FILE  ("")
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if.slave)
    );

    typedef struct packed {
        logic b;
        logic l;
    } beat_t;

    typedef struct {
        bit         dut;    // 0 = dut_a (SCALE 1), 1 = dut_b (SCALE 2)
        logic [2:0] glyph;
        logic [3:0] row;
        logic [7:0] word;   // expected glyph row, MSB = leftmost pixel
        int         mode;   // pix_ready: 0 always, 1 toggle 1,0,..., 2 random
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    beat_t qa [$];
    beat_t qb [$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic pa_v = 0, pa_r = 0, pa_b = 0, pa_l = 0;
    logic pb_v = 0, pb_r = 0, pb_b = 0, pb_l = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_a(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            qa.push_back('{b: w[7-i], l: (i == 7)});
        end
    endtask

    task automatic push_b(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 2; k++) begin
                qb.push_back('{b: w[7-i], l: (i == 7 && k == 1)});
            end
        end
    endtask

    // Inputs for the coming rising edge are already driven and outputs are
    // stable: score the beat (if any), then advance to the next falling edge.
    task automatic cycle();
        beat_t e;
        if (!reset) begin
            if (pa_v && !pa_r) begin
                chk1("a_hold_valid", a_if.pix_valid, 1'b1);
                chk1("a_hold_bit",   a_if.pix_bit,   pa_b);
                chk1("a_hold_last",  a_if.pix_last,  pa_l);
            end
            if (pb_v && !pb_r) begin
                chk1("b_hold_valid", b_if.pix_valid, 1'b1);
                chk1("b_hold_bit",   b_if.pix_bit,   pb_b);
                chk1("b_hold_last",  b_if.pix_last,  pb_l);
            end
            if (a_if.pix_valid && a_if.pix_ready) begin
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_extra_beat: got beat bit=%0b, expected no beat (cycle %0d)",
                             a_if.pix_bit, cyc);
                end else begin
                    e = qa.pop_front();
                    chk1("a_pix_bit",  a_if.pix_bit,  e.b);
                    chk1("a_pix_last", a_if.pix_last, e.l);
                end
            end
            if (b_if.pix_valid && b_if.pix_ready) begin
                if (qb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_extra_beat: got beat bit=%0b, expected no beat (cycle %0d)",
                             b_if.pix_bit, cyc);
                end else begin
                    e = qb.pop_front();
                    chk1("b_pix_bit",  b_if.pix_bit,  e.b);
                    chk1("b_pix_last", b_if.pix_last, e.l);
                end
            end
        end
        pa_v = a_if.pix_valid; pa_r = a_if.pix_ready; pa_b = a_if.pix_bit; pa_l = a_if.pix_last;
        pb_v = b_if.pix_valid; pb_r = b_if.pix_ready; pb_b = b_if.pix_bit; pb_l = b_if.pix_last;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_vec(input vec_t v);
        int   n;
        int   q_left;
        logic rdy;
        if (v.dut == 1'b0) begin
            push_a(v.word);
            a_if.glyph_idx = v.glyph;
            a_if.row_idx   = v.row;
            a_if.req_valid = 1'b1;
        end else begin
            push_b(v.word);
            b_if.glyph_idx = v.glyph[1:0];
            b_if.row_idx   = v.row;
            b_if.req_valid = 1'b1;
        end

        n = 0;
        while (((v.dut == 1'b0) ? a_if.req_ready : b_if.req_ready) !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        if (n >= 20) chki("req_ready_timeout", n, 0);

        cycle();   // request taken on this edge; now in FETCH
        a_if.req_valid = 1'b0;
        b_if.req_valid = 1'b0;
        chk1("fetch_pix_valid", (v.dut == 1'b0) ? a_if.pix_valid : b_if.pix_valid, 1'b0);
        chk1("fetch_req_ready", (v.dut == 1'b0) ? a_if.req_ready : b_if.req_ready, 1'b0);

        n = 0;
        q_left = (v.dut == 1'b0) ? qa.size() : qb.size();
        while (q_left != 0 && n < 200) begin
            case (v.mode)
                0:       rdy = 1'b1;
                1:       rdy = (n % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (v.dut == 1'b0) a_if.pix_ready = rdy;
            else               b_if.pix_ready = rdy;
            cycle();
            n++;
            q_left = (v.dut == 1'b0) ? qa.size() : qb.size();
        end
        chki("drain_left", q_left, 0);
        if (v.mode == 0) chki("drain_cycles", n, v.dut ? 17 : 9);
        a_if.pix_ready = 1'b1;
        b_if.pix_ready = 1'b1;
        // Last beat just accepted: block must already be back in IDLE.
        chk1("done_req_ready", (v.dut == 1'b0) ? a_if.req_ready : b_if.req_ready, 1'b1);
        chk1("done_pix_valid", (v.dut == 1'b0) ? a_if.pix_valid : b_if.pix_valid, 1'b0);
        qa.delete();
        qb.delete();
    endtask

    initial begin
        int acc, beats, t1, t2;

        vecs[0]  = '{1'b0, 3'd1, 4'd1,  8'hFF, 0};   // 'I' top bar, timing
        vecs[1]  = '{1'b0, 3'd3, 4'd3,  8'h6C, 0};
        vecs[2]  = '{1'b0, 3'd2, 4'd9,  8'h07, 1};   // ready toggling
        vecs[3]  = '{1'b0, 3'd5, 4'd2,  8'h00, 0};   // glyph past NUM_GLYPHS
        vecs[4]  = '{1'b0, 3'd7, 4'd3,  8'h00, 2};
        vecs[5]  = '{1'b0, 3'd4, 4'd1,  8'h00, 0};   // stored glyph, no table entry
        vecs[6]  = '{1'b0, 3'd0, 4'd7,  8'h00, 0};
        vecs[7]  = '{1'b0, 3'd2, 4'd4,  8'hE0, 2};
        vecs[8]  = '{1'b0, 3'd3, 4'd1,  8'h10, 2};
        vecs[9]  = '{1'b0, 3'd3, 4'd11, 8'hC6, 0};
        vecs[10] = '{1'b0, 3'd1, 4'd15, 8'h00, 0};
        vecs[11] = '{1'b0, 3'd1, 4'd6,  8'h38, 1};
        vecs[12] = '{1'b0, 3'd2, 4'd12, 8'hFF, 0};
        vecs[13] = '{1'b1, 3'd3, 4'd3,  8'h6C, 0};   // SCALE 2
        vecs[14] = '{1'b1, 3'd2, 4'd9,  8'h07, 1};
        vecs[15] = '{1'b1, 3'd1, 4'd13, 8'hFF, 2};
        vecs[16] = '{1'b1, 3'd3, 4'd9,  8'hFE, 0};

        a_if.req_valid = 1'b0; a_if.glyph_idx = '0; a_if.row_idx = '0; a_if.pix_ready = 1'b1;
        b_if.req_valid = 1'b0; b_if.glyph_idx = '0; b_if.row_idx = '0; b_if.pix_ready = 1'b1;

        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk1("rst_a_req_ready", a_if.req_ready, 1'b1);
        chk1("rst_a_pix_valid", a_if.pix_valid, 1'b0);
        chk1("rst_a_pix_bit",   a_if.pix_bit,   1'b0);
        chk1("rst_a_pix_last",  a_if.pix_last,  1'b0);
        chk1("rst_b_req_ready", b_if.req_ready, 1'b1);
        chk1("rst_b_pix_valid", b_if.pix_valid, 1'b0);
        chk1("rst_b_pix_bit",   b_if.pix_bit,   1'b0);
        chk1("rst_b_pix_last",  b_if.pix_last,  1'b0);
        reset = 1'b0;
        cycle();

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i]);
        end

        // Reset in the middle of a row: aborts at once, no pix_last.
        push_a(8'hFF);
        a_if.glyph_idx = 3'd1; a_if.row_idx = 4'd1; a_if.req_valid = 1'b1;
        cycle();                               // accept
        a_if.req_valid = 1'b0;
        cycle();                               // FETCH
        for (int i = 0; i < 3; i++) cycle();   // three beats consumed
        chk1("mid_row_valid", a_if.pix_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk1("abort_pix_valid", a_if.pix_valid, 1'b0);
        chk1("abort_pix_last",  a_if.pix_last,  1'b0);
        chk1("abort_req_ready", a_if.req_ready, 1'b1);
        qa.delete();
        @(negedge clk);
        reset = 1'b0;
        pa_v = 1'b0;
        pb_v = 1'b0;
        run_vec('{1'b0, 3'd3, 4'd8, 8'hFE, 0});

        // Back-to-back with req_valid held: second row 10 cycles after first,
        // and a changed request during SHIFT must not disturb the first row.
        push_a(8'hFF);
        push_a(8'hFE);
        a_if.glyph_idx = 3'd1; a_if.row_idx = 4'd1; a_if.req_valid = 1'b1;
        acc = 0; beats = 0; t1 = 0; t2 = 0;
        for (int i = 0; i < 40 && qa.size() != 0; i++) begin
            if (a_if.req_valid && a_if.req_ready) acc++;
            if (a_if.pix_valid) begin
                beats++;
                if (beats == 1) t1 = cyc;
                if (beats == 9) t2 = cyc;
            end
            cycle();
            if (acc == 1) begin
                a_if.glyph_idx = 3'd3;
                a_if.row_idx   = 4'd8;
            end
            if (acc == 2) a_if.req_valid = 1'b0;
        end
        a_if.req_valid = 1'b0;
        chki("b2b_left",     qa.size(), 0);
        chki("b2b_beats",    beats, 16);
        chki("b2b_accepts",  acc, 2);
        chki("b2b_spacing",  t2 - t1, 10);
        chk1("b2b_req_ready", a_if.req_ready, 1'b1);
        qa.delete();
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
